// File: rtl/execute_issue_stage_if.sv
// Issue-side and ALU-side signal bundle for execute_issue_stage.
// master = decode/forwarding/ALU environment, slave = the issue stage itself.
interface execute_issue_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_control;
    logic [4:0]  in_rs_addr;
    logic [4:0]  in_rt_addr;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_rs_value;
    logic [31:0] in_rt_value;
    logic [15:0] in_immediate;
    logic        in_use_immediate;
    logic        fwd_ex_valid;
    logic [4:0]  fwd_ex_addr;
    logic [31:0] fwd_ex_data;
    logic        fwd_mem_valid;
    logic [4:0]  fwd_mem_addr;
    logic [31:0] fwd_mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  control;
    logic [31:0] operand0;
    logic [31:0] operand1;
    logic [4:0]  dest_addr;

    modport master (
        output flush, in_valid, in_control, in_rs_addr, in_rt_addr, in_rd_addr,
               in_rs_value, in_rt_value, in_immediate, in_use_immediate,
               fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
               fwd_mem_valid, fwd_mem_addr, fwd_mem_data, out_ready,
        input  in_ready, out_valid, control, operand0, operand1, dest_addr
    );

    modport slave (
        input  flush, in_valid, in_control, in_rs_addr, in_rt_addr, in_rd_addr,
               in_rs_value, in_rt_value, in_immediate, in_use_immediate,
               fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
               fwd_mem_valid, fwd_mem_addr, fwd_mem_data, out_ready,
        output in_ready, out_valid, control, operand0, operand1, dest_addr
    );
endinterface

// File: rtl/execute_issue_stage.sv
// ID/EX issue stage: operand forwarding, immediate selection and a 2-entry skid queue.
// Define STALL_COUNTER_EN to add the stall_cycles output counting back-pressured cycles.
module execute_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    execute_issue_stage_if.slave bus
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int DATA_W = 32;
    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    function automatic logic [DATA_W-1:0] resolve_operand(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] rf_value,
        input logic              ex_valid,
        input logic [4:0]        ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_valid,
        input logic [4:0]        mem_addr,
        input logic [DATA_W-1:0] mem_data
    );
        logic [DATA_W-1:0] value;
        value = rf_value;
        if (addr != 5'd0) begin
            if (ex_valid && ex_addr == addr) value = ex_data;
            else if (mem_valid && mem_addr == addr) value = mem_data;
        end
        return value;
    endfunction

    function automatic logic [DATA_W-1:0] select_operand1(
        input logic [3:0]        ctl,
        input logic              use_imm,
        input logic [15:0]       imm,
        input logic [DATA_W-1:0] rt_value
    );
        logic signed [DATA_W-1:0] imm_sext;
        logic [DATA_W-1:0]        value;
        imm_sext = DATA_W'(signed'(imm));
        if (!use_imm) begin
            value = rt_value;
        end else begin
            case (ctl)
                4'b0000, 4'b0001, 4'b0011, 4'b0100: value = {16'd0, imm};
                4'b1000, 4'b1001, 4'b1010:          value = {27'd0, imm[10:6]};
                default:                            value = imm_sext;
            endcase
        end
        return value;
    endfunction

    logic [1:0]        count;
    logic [1:0]        next_count;
    logic              in_ready_p1;
    logic              out_valid_p1;
    logic              accept;
    logic              pop;
    logic              load_head_new;
    logic              load_tail;
    logic              load_head_tail;

    logic [DATA_W-1:0] entry_operand0_p0;
    logic [DATA_W-1:0] entry_operand1_p0;
    logic [DATA_W-1:0] entry_rt_p0;

    logic [3:0]        head_control_p1;
    logic [DATA_W-1:0] head_operand0_p1;
    logic [DATA_W-1:0] head_operand1_p1;
    logic [4:0]        head_dest_p1;
    logic [3:0]        tail_control_p1;
    logic [DATA_W-1:0] tail_operand0_p1;
    logic [DATA_W-1:0] tail_operand1_p1;
    logic [4:0]        tail_dest_p1;

    // Stage p0: resolve the incoming instruction's operands at the accept edge
    assign entry_operand0_p0 = resolve_operand(bus.in_rs_addr, bus.in_rs_value,
        bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
        bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
    assign entry_rt_p0 = resolve_operand(bus.in_rt_addr, bus.in_rt_value,
        bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
        bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
    assign entry_operand1_p0 = select_operand1(bus.in_control, bus.in_use_immediate,
        bus.in_immediate, entry_rt_p0);

    assign accept = bus.in_valid && in_ready_p1 && !bus.flush;
    assign pop    = out_valid_p1 && bus.out_ready;

    always_comb begin
        next_count     = count;
        load_head_new  = 1'b0;
        load_tail      = 1'b0;
        load_head_tail = 1'b0;
        if (bus.flush) begin
            next_count = 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (accept) begin
                        next_count    = 2'd1;
                        load_head_new = 1'b1;
                    end
                end
                2'd1: begin
                    // Simultaneous push/pop replaces the head in place
                    if (accept && pop) begin
                        load_head_new = 1'b1;
                    end else if (accept) begin
                        next_count = 2'd2;
                        load_tail  = 1'b1;
                    end else if (pop) begin
                        next_count = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        next_count     = 2'd1;
                        load_head_tail = 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage p1: queue registers presented to the ALU
    always_ff @(posedge clock) begin
        if (reset) begin
            count            <= 2'd0;
            in_ready_p1      <= 1'b1;
            out_valid_p1     <= 1'b0;
            head_control_p1  <= 4'd0;
            head_operand0_p1 <= '0;
            head_operand1_p1 <= '0;
            head_dest_p1     <= 5'd0;
        end else begin
            count        <= next_count;
            in_ready_p1  <= next_count < FULL_COUNT;
            out_valid_p1 <= next_count != 2'd0;
            if (load_head_new) begin
                head_control_p1  <= bus.in_control;
                head_operand0_p1 <= entry_operand0_p0;
                head_operand1_p1 <= entry_operand1_p0;
                head_dest_p1     <= bus.in_rd_addr;
            end else if (load_head_tail) begin
                head_control_p1  <= tail_control_p1;
                head_operand0_p1 <= tail_operand0_p1;
                head_operand1_p1 <= tail_operand1_p1;
                head_dest_p1     <= tail_dest_p1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (load_tail && !reset) begin
            tail_control_p1  <= bus.in_control;
            tail_operand0_p1 <= entry_operand0_p0;
            tail_operand1_p1 <= entry_operand1_p0;
            tail_dest_p1     <= bus.in_rd_addr;
        end
    end

    assign bus.in_ready  = in_ready_p1;
    assign bus.out_valid = out_valid_p1;
    assign bus.control   = head_control_p1;
    assign bus.operand0  = head_operand0_p1;
    assign bus.operand1  = head_operand1_p1;
    assign bus.dest_addr = head_dest_p1;

`ifdef STALL_COUNTER_EN
    // Flush deliberately leaves the counter alone; it wraps naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_valid_p1 && !bus.out_ready) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_execute_issue_stage.sv
// Scoreboard bench for execute_issue_stage: directed cases followed by randomized traffic.
// Build with STALL_COUNTER_EN defined to also exercise the stall counter.
module tb_execute_issue_stage;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    execute_issue_stage_if bus ();
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    execute_issue_stage #(.DEPTH(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus)
`ifdef STALL_COUNTER_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        logic [3:0]  control;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [4:0]  dest;
    } entry_t;

    entry_t      exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_stall = 32'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: what the ALU should see for the instruction currently offered
    function automatic entry_t model_entry();
        entry_t      e;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        longint      imm_u;
        longint      imm_s;
        rs_v = bus.in_rs_value;
        rt_v = bus.in_rt_value;
        if (bus.in_rs_addr != 0 && bus.fwd_mem_valid && bus.fwd_mem_addr == bus.in_rs_addr) rs_v = bus.fwd_mem_data;
        if (bus.in_rs_addr != 0 && bus.fwd_ex_valid && bus.fwd_ex_addr == bus.in_rs_addr) rs_v = bus.fwd_ex_data;
        if (bus.in_rt_addr != 0 && bus.fwd_mem_valid && bus.fwd_mem_addr == bus.in_rt_addr) rt_v = bus.fwd_mem_data;
        if (bus.in_rt_addr != 0 && bus.fwd_ex_valid && bus.fwd_ex_addr == bus.in_rt_addr) rt_v = bus.fwd_ex_data;
        imm_u = longint'(bus.in_immediate);
        imm_s = (imm_u >= 32768) ? imm_u - 65536 : imm_u;
        e.control = bus.in_control;
        e.op0     = rs_v;
        e.dest    = bus.in_rd_addr;
        if (!bus.in_use_immediate) e.op1 = rt_v;
        else if (bus.in_control inside {4'd0, 4'd1, 4'd3, 4'd4}) e.op1 = 32'(imm_u);
        else if (bus.in_control inside {4'd8, 4'd9, 4'd10}) e.op1 = 32'((imm_u / 64) % 32);
        else e.op1 = 32'(imm_s);
        return e;
    endfunction

    // One clock: record the expected entry if the offered op is taken at this edge
    task automatic tick();
        bit     pend;
        entry_t e;
        pend = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && (bus.flush === 1'b0) && (reset === 1'b0);
        e = model_entry();
        @(posedge clock);
        if (pend) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.in_control = 0;
        bus.in_rs_addr = 0; bus.in_rt_addr = 0; bus.in_rd_addr = 0;
        bus.in_rs_value = 0; bus.in_rt_value = 0; bus.in_immediate = 0; bus.in_use_immediate = 0;
        bus.fwd_ex_valid = 0; bus.fwd_ex_addr = 0; bus.fwd_ex_data = 0;
        bus.fwd_mem_valid = 0; bus.fwd_mem_addr = 0; bus.fwd_mem_data = 0;
        bus.out_ready = 0;
    endtask

    task automatic offer(input logic [3:0] ctl, input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd);
        bus.in_valid = 1; bus.in_control = ctl;
        bus.in_rs_addr = rs; bus.in_rs_value = rsv;
        bus.in_rt_addr = rt; bus.in_rt_value = rtv;
        bus.in_rd_addr = rd; bus.in_use_immediate = 0;
        bus.fwd_ex_valid = 0; bus.fwd_mem_valid = 0;
    endtask

    // Monitor: state seen at the falling edge reflects the last rising edge
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
            if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
                check("control", 32'(bus.control), 32'(exp_q[0].control));
                check("operand0", bus.operand0, exp_q[0].op0);
                check("operand1", bus.operand1, exp_q[0].op1);
                check("dest_addr", 32'(bus.dest_addr), 32'(exp_q[0].dest));
            end
`ifdef STALL_COUNTER_EN
            check("stall_cycles", stall_cycles, exp_stall);
            if (reset) exp_stall = 32'd0;
            else if (exp_q.size() != 0 && !bus.out_ready) exp_stall = exp_stall + 32'd1;
`endif
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
            if (reset || bus.flush) exp_q.delete();
        end
    end

    initial begin
        reset = 1;
        idle_inputs();
        tick();
        mon_en = 1;
        tick();
        reset = 0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst control", 32'(bus.control), 32'd0);
        check("rst operand0", bus.operand0, 32'd0);
        check("rst operand1", bus.operand1, 32'd0);
        check("rst dest_addr", 32'(bus.dest_addr), 32'd0);
`ifdef STALL_COUNTER_EN
        check("rst stall_cycles", stall_cycles, 32'd0);
`endif

        // Single add with ALU ready
        bus.out_ready = 1;
        offer(4'b0010, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9);
        tick();
        bus.in_valid = 0;
        check("add out_valid", 32'(bus.out_valid), 32'd1);
        check("add control", 32'(bus.control), 32'h2);
        check("add operand0", bus.operand0, 32'd5);
        check("add operand1", bus.operand1, 32'd7);
        tick();
        check("add drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure: third op must wait
        bus.out_ready = 0;
        offer(4'b0001, 5'd1, 32'h11, 5'd2, 32'h22, 5'd1);
        tick();
        offer(4'b0011, 5'd1, 32'h33, 5'd2, 32'h44, 5'd2);
        tick();
        check("full in_ready", 32'(bus.in_ready), 32'd0);
        offer(4'b0110, 5'd1, 32'h55, 5'd2, 32'h66, 5'd3);
        tick();
        tick();
        check("held head", 32'(bus.control), 32'h1);
        bus.out_ready = 1;
        tick();
        check("second head", 32'(bus.control), 32'h3);
        tick();
        bus.in_valid = 0;
        check("third head", 32'(bus.control), 32'h6);
        tick();
        check("bp drained", 32'(bus.out_valid), 32'd0);

        // Forwarding priority
        offer(4'b0010, 5'd2, 32'h1234, 5'd5, 32'h77, 5'd4);
        bus.fwd_ex_valid = 1;  bus.fwd_ex_addr = 5'd2;  bus.fwd_ex_data = 32'hAAAA;
        bus.fwd_mem_valid = 1; bus.fwd_mem_addr = 5'd2; bus.fwd_mem_data = 32'hBBBB;
        tick();
        check("fwd ex wins", bus.operand0, 32'hAAAA);
        bus.fwd_ex_valid = 0;
        tick();
        check("fwd mem", bus.operand0, 32'hBBBB);
        bus.in_rs_addr = 5'd0; bus.in_rs_value = 32'h55;
        bus.fwd_ex_valid = 1; bus.fwd_ex_addr = 5'd0; bus.fwd_mem_addr = 5'd0;
        tick();
        check("fwd r0", bus.operand0, 32'h55);
        bus.in_valid = 0; bus.fwd_ex_valid = 0; bus.fwd_mem_valid = 0;
        tick();

        // Immediate selection
        offer(4'b0001, 5'd1, 32'h1, 5'd2, 32'h2, 5'd6);
        bus.in_use_immediate = 1; bus.in_immediate = 16'hFFF0;
        tick();
        check("imm zext", bus.operand1, 32'h0000FFF0);
        bus.in_control = 4'b0010;
        tick();
        check("imm sext", bus.operand1, 32'hFFFFFFF0);
        bus.in_control = 4'b1000; bus.in_immediate = 16'h0140;
        tick();
        check("imm shamt", bus.operand1, 32'd5);
        bus.in_valid = 0; bus.in_use_immediate = 0;
        tick();

        // Flush with a full queue drops the offered op too
        bus.out_ready = 0;
        offer(4'b0010, 5'd1, 32'h10, 5'd2, 32'h20, 5'd10);
        tick();
        offer(4'b0011, 5'd1, 32'h30, 5'd2, 32'h40, 5'd11);
        tick();
        offer(4'b0100, 5'd1, 32'h50, 5'd2, 32'h60, 5'd12);
        bus.flush = 1;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("flush no ghost", 32'(bus.out_valid), 32'd0);

        // Reset with an entry queued
        offer(4'b0010, 5'd1, 32'h1, 5'd2, 32'h2, 5'd13);
        tick();
        bus.in_valid = 0; reset = 1;
        tick();
        reset = 0;
        check("reset drop", 32'(bus.out_valid), 32'd0);

        // Randomized traffic
        repeat (500) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_control = 4'($urandom_range(0, 15));
            bus.in_rs_addr = 5'($urandom_range(0, 3));
            bus.in_rt_addr = 5'($urandom_range(0, 3));
            bus.in_rd_addr = 5'($urandom_range(0, 31));
            bus.in_rs_value = $urandom; bus.in_rt_value = $urandom;
            bus.in_immediate = 16'($urandom); bus.in_use_immediate = 1'($urandom_range(0, 1));
            bus.fwd_ex_valid = 1'($urandom_range(0, 1)); bus.fwd_ex_addr = 5'($urandom_range(0, 3));
            bus.fwd_ex_data = $urandom;
            bus.fwd_mem_valid = 1'($urandom_range(0, 1)); bus.fwd_mem_addr = 5'($urandom_range(0, 3));
            bus.fwd_mem_data = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_inputs();
        reset = 0;
        bus.out_ready = 1;
        repeat (3) tick();

`ifdef STALL_COUNTER_EN
        reset = 1;
        tick();
        reset = 0;
        bus.out_ready = 0;
        offer(4'b0010, 5'd1, 32'h1, 5'd2, 32'h2, 5'd7);
        tick();
        bus.in_valid = 0;
        repeat (4) tick();
        check("stall count", stall_cycles, 32'd4);
        bus.flush = 1; bus.out_ready = 1;
        tick();
        bus.flush = 0;
        check("stall after flush", stall_cycles, 32'd4);
        tick();
        check("stall idle", stall_cycles, 32'd4);
`endif

        @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_issue_stage.md
# execute_issue_stage

ID/EX boundary stage that sits directly upstream of the arithmetic logic unit. It captures decoded instructions from decode, resolves register-operand forwarding from the EX and MEM stages, and selects or extends the immediate. It buffers up to two issued operations in a skid queue and presents the head entry as `control`, `operand0` and `operand1` to the ALU under a valid/ready handshake.

## Interface
- DEPTH, 2, queue entries; fixed at 2, other values unsupported
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all queued entries; has priority over accept
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  stage can accept; registered, equals queue-count < 2
- in_control  input  4  ALU opcode (0000 AND, 0001 OR, 0010 add, 0011 XOR, 0100 NOR, 0110 sub, 0111 slt, 1000 sll, 1001 srl, 1010 sra)
- in_rs_addr, in_rt_addr, in_rd_addr  input  5  source and destination register numbers
- in_rs_value, in_rt_value  input  32  register-file read data
- in_immediate  input  16  instruction immediate field
- in_use_immediate  input  1  operand1 comes from the immediate, not rt
- fwd_ex_valid, fwd_mem_valid  input  1  forwarding sources are writing a register
- fwd_ex_addr, fwd_mem_addr  input  5  forwarding destination registers
- fwd_ex_data, fwd_mem_data  input  32  forwarding data
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU/EX consumes the head entry
- control  output  4  head opcode
- operand0, operand1  output  32  head operands
- dest_addr  output  5  head destination register
- stall_cycles  output  32  present only with STALL_COUNTER_EN

## Operation
- An input is accepted on a cycle where in_valid && in_ready && !flush.
- Forwarding is resolved at accept time, separately for rs and rt:
  - EX wins over MEM, and MEM wins over register-file data.
  - A source matches only if its valid bit is set, its address equals the operand address, and the address is non-zero.
  - Register 0 always reads in_*_value unmodified.
- operand0 is the resolved rs value.
- operand1 selection:
  - in_use_immediate=0: the resolved rt value.
  - in_use_immediate=1, opcode 0000/0001/0011/0100: zero-extended immediate.
  - in_use_immediate=1, opcode 1000/1001/1010: {27'b0, in_immediate[10:6]} (shamt).
  - in_use_immediate=1, any other opcode: sign-extended immediate.
- Queue behaviour:
  - 2-entry FIFO; the head drives control/operand0/operand1/dest_addr.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle at count 1: count stays 1 and the new entry becomes the head.
  - Pop at count 2 promotes the tail entry to head.
  - Push at count 2 is impossible because in_ready=0.
- Outputs when out_valid=0: control/operand/dest_addr hold their last values. Consumers must qualify them with out_valid.
- flush: the next cycle has count=0, out_valid=0, in_ready=1, and register contents are unchanged. An in_valid in the same cycle is dropped. A pop in the same cycle is still counted as consumed by the ALU.

## Timing
- Latency: accept at edge N, so out_valid=1 with that entry's data after edge N (visible in cycle N+1).
- Throughput: 1 op/cycle when out_ready is held high.
- in_ready is registered: it reflects count after the previous edge and never depends combinationally on out_ready.
- Forwarding inputs are sampled only at the accept edge. Later changes do not update queued entries.
- Reset values: out_valid=0, in_ready=1 (count 0), control=4'b0000, operand0=0, operand1=0, dest_addr=0, stall_cycles=0.
- Reset mid-operation drops all entries on that edge. reset has priority over flush.

## Configuration
- STALL_COUNTER_EN defined:
  - stall_cycles increments by 1 on every cycle with out_valid && !out_ready.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared by reset only; flush does not clear it.
- STALL_COUNTER_EN undefined: stall_cycles port and counter logic are absent.

## Test plan
- Reset, then push add rs=r3 (value 5), rt=r4 (value 7), out_ready=1 → next cycle out_valid=1, control=0010, operand0=5, operand1=7; the cycle after, out_valid=0.
- Hold out_ready=0 and offer 3 ops → the first two are accepted, in_ready=0 after the second, the third is held; raise out_ready → ops emerge in order and the third is accepted.
- Forwarding priority: rs=r2, fwd_ex (r2, 0xAAAA), fwd_mem (r2, 0xBBBB) → operand0=0xAAAA. Same with rs=r0 and both sources addressed r0 → operand0=in_rs_value.
- Immediate selection, in_immediate=0xFFF0:
  - OR → operand1=0x0000FFF0.
  - add → operand1=0xFFFFFFF0.
  - sll with immediate 0x0140 → operand1=5.
- Flush with 2 entries queued and in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered op never appears. Reset asserted with an entry queued → out_valid=0 next cycle.
- With STALL_COUNTER_EN: 4 cycles of out_valid=1, out_ready=0 → stall_cycles=4. Flush → stall_cycles remains 4.
